// File: rtl/result_fifo.sv
// result_fifo: small result buffer between the mini CPU core and an external
// consumer. The core pushes (data, tag) pairs and never stalls; the consumer
// drains them over valid/ready. A push into a full FIFO without a
// simultaneous pop is dropped and recorded in a sticky flag and a saturating
// counter.
// Optional build macro: RESULT_FIFO_PARITY_EN adds a stored per-entry parity
// bit, presented on out_parity.
module result_fifo #(
  parameter int DATA_W = 8,
  parameter int TAG_W  = 4,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [TAG_W-1:0]  wr_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic [7:0]        drop_cnt,
`ifdef RESULT_FIFO_PARITY_EN
  output logic              out_parity,
`endif
  input  logic              clr_ovf
);

`ifdef RESULT_FIFO_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int ENTRY_W = DATA_W + TAG_W + PAR_W;

  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = 1;

  // Storage and control state
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]    count_q, count_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;

  logic               push;
  logic               pop;
  logic               drop;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head_entry;

  // Entry packing: {parity (optional), tag, data}
`ifdef RESULT_FIFO_PARITY_EN
  assign wr_entry = {^{wr_tag, wr_data}, wr_tag, wr_data};
  assign out_parity = head_entry[ENTRY_W-1];
`else
  assign wr_entry = {wr_tag, wr_data};
`endif

  // Status flags come only from registered state, never from inputs
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_FULL);
  assign out_valid = !empty;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

  // Head entry is a combinational read at the read pointer
  assign head_entry = mem_q[rd_ptr_q];
  assign out_data   = head_entry[DATA_W-1:0];
  assign out_tag    = head_entry[DATA_W +: TAG_W];

  // Handshake decode: a pop frees a slot, so a full FIFO still accepts a push
  always_comb begin
    pop  = out_valid & out_ready;
    push = wr_en & (!full | pop);
    drop = wr_en & full & !pop;
  end

  // Next-state for pointers, occupancy and the write into the array
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_entry;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Overflow bookkeeping: a drop in the same cycle as a clear wins,
  // so the counter restarts at 1 rather than 0
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (clr_ovf) begin
        drop_cnt_d = 8'd1;
      end else if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
      drop_cnt_d = 8'd0;
    end
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Entry registers, cleared on reset so the head never reads as X
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst) begin
          mem_q[gi] <= '0;
        end else begin
          mem_q[gi] <= mem_d[gi];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_result_fifo.sv
// tb_result_fifo: directed test for result_fifo. A queue-based reference
// model tracks the expected contents and overflow state; a compare process
// checks every output against it on each falling edge, and literal checks
// in the stimulus pin the model to hand-computed values.
module tb_result_fifo;
  localparam int DATA_W = 8;
  localparam int TAG_W  = 4;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [TAG_W-1:0]  wr_tag = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic [7:0]        drop_cnt;
  logic              clr_ovf = 1'b0;
`ifdef RESULT_FIFO_PARITY_EN
  logic              out_parity;
`endif

  int checks = 0;
  int errors = 0;

  result_fifo #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_tag(wr_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .count(count), .full(full), .empty(empty), .overflow(overflow), .drop_cnt(drop_cnt),
`ifdef RESULT_FIFO_PARITY_EN
    .out_parity(out_parity),
`endif
    .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  // Reference model
  typedef struct {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic              par;
  } entry_t;

  entry_t m_q[$];
  bit     m_ovf  = 0;
  int     m_drop = 0;
  bit     m_live = 0;
  bit     m_pop, m_push, m_drp;
  entry_t m_e;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_ovf  = 0;
      m_drop = 0;
      m_live = 1;
    end else if (m_live) begin
      m_pop  = (m_q.size() != 0) && out_ready;
      m_push = wr_en && ((m_q.size() < DEPTH) || m_pop);
      m_drp  = wr_en && !m_push;
      if (m_pop) void'(m_q.pop_front());
      if (m_push) begin
        m_e.data = wr_data;
        m_e.tag  = wr_tag;
        m_e.par  = ^{wr_tag, wr_data};
        m_q.push_back(m_e);
      end
      if (m_drp) begin
        m_ovf  = 1;
        m_drop = clr_ovf ? 1 : (m_drop >= 255 ? 255 : m_drop + 1);
      end else if (clr_ovf) begin
        m_ovf  = 0;
        m_drop = 0;
      end
    end
  end

  // Compare DUT against the model on every falling edge
  always @(negedge clk) begin
    if (m_live) begin
      chk("out_valid", out_valid, m_q.size() != 0);
      chk("count", count, m_q.size());
      chk("full", full, m_q.size() == DEPTH);
      chk("empty", empty, m_q.size() == 0);
      chk("overflow", overflow, m_ovf);
      chk("drop_cnt", drop_cnt, m_drop);
      if (m_q.size() != 0) begin
        chk("out_data", out_data, m_q[0].data);
        chk("out_tag", out_tag, m_q[0].tag);
`ifdef RESULT_FIFO_PARITY_EN
        chk("out_parity", out_parity, m_q[0].par);
`endif
      end
    end
  end

  // Drive one cycle of inputs; returns just after the following falling edge
  task automatic step(input bit we, input logic [7:0] d, input logic [3:0] t,
                      input bit rdy, input bit clr);
    wr_en     = we;
    wr_data   = d;
    wr_tag    = t;
    out_ready = rdy;
    clr_ovf   = clr;
    @(negedge clk);
    #1;
    $display("t=%0t we=%0b d=%02h t=%0h rdy=%0b clr=%0b -> valid=%0b head=%02h/%0h count=%0d ovf=%0b drops=%0d",
             $time, we, d, t, rdy, clr, out_valid, out_data, out_tag, count, overflow, drop_cnt);
  endtask

  initial begin
    // Reset then idle
    rst = 1'b1;
    step(0, 8'h00, 4'h0, 0, 0);
    step(0, 8'h00, 4'h0, 0, 0);
    rst = 1'b0;
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_tag", out_tag, 4'h0);
    chk("rst_ovf", overflow, 0);
    step(0, 8'h00, 4'h0, 1, 0);
    chk("idle_empty", empty, 1);

    // Three pushes held, then drained in order
    step(1, 8'h11, 4'h1, 0, 0);
    chk("lat1_valid", out_valid, 1);
    chk("lat1_data", out_data, 8'h11);
    step(1, 8'h22, 4'h2, 0, 0);
    step(1, 8'h33, 4'h3, 0, 0);
    chk("three_count", count, 3);
    chk("head0_data", out_data, 8'h11);
    chk("head0_tag", out_tag, 4'h1);
    step(0, 8'h00, 4'h0, 1, 0);
    chk("head1_data", out_data, 8'h22);
    chk("head1_tag", out_tag, 4'h2);
    step(0, 8'h00, 4'h0, 1, 0);
    chk("head2_data", out_data, 8'h33);
    chk("head2_tag", out_tag, 4'h3);
    step(0, 8'h00, 4'h0, 1, 0);
    chk("drained_empty", empty, 1);

    // Fill, then two dropped pushes
    for (int i = 0; i < 4; i++) step(1, 8'hA1 + 8'(i), 4'(4 + i), 0, 0);
    step(1, 8'h55, 4'h5, 0, 0);
    step(1, 8'h55, 4'h5, 0, 0);
    chk("ovf_full", full, 1);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drops", drop_cnt, 2);
    chk("ovf_head", out_data, 8'hA1);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_drain_data", out_data, 8'hA1 + 8'(i));
      chk("ovf_drain_tag", out_tag, 4'(4 + i));
      step(0, 8'h00, 4'h0, 1, 0);
    end
    chk("ovf_drain_empty", empty, 1);
    step(0, 8'h00, 4'h0, 0, 1);
    chk("clr_flag", overflow, 0);
    chk("clr_drops", drop_cnt, 0);

    // Full FIFO with simultaneous push and pop across pointer wrap
    for (int i = 0; i < 4; i++) step(1, 8'h01 + 8'(i), 4'(i), 0, 0);
    for (int i = 0; i < 10; i++) begin
      chk("stream_head", out_data, (i < 4) ? 8'h01 + 8'(i) : 8'h10 + 8'(i - 4));
      step(1, 8'h10 + 8'(i), 4'(i), 1, 0);
      chk("stream_count", count, 4);
      chk("stream_drops", drop_cnt, 0);
    end

    // Drop counter saturation, then clear coinciding with a drop
    for (int i = 0; i < 300; i++) begin
      wr_en = 1'b1; wr_data = 8'h55; wr_tag = 4'h5; out_ready = 1'b0; clr_ovf = 1'b0;
      @(negedge clk);
    end
    #1;
    chk("sat_drops", drop_cnt, 255);
    chk("sat_flag", overflow, 1);
    step(1, 8'h55, 4'h5, 0, 1);
    chk("clr_drop_flag", overflow, 1);
    chk("clr_drop_cnt", drop_cnt, 1);

    // Reset with entries queued and a push in the same cycle
    step(0, 8'h00, 4'h0, 1, 0);
    chk("pre_rst_count", count, 3);
    rst = 1'b1;
    step(1, 8'hEE, 4'hE, 0, 0);
    rst = 1'b0;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 8'h00);

    // Push into empty FIFO while ready is high: stored, not popped
    step(1, 8'h07, 4'h0, 1, 0);
    chk("empty_push_count", count, 1);
    chk("empty_push_data", out_data, 8'h07);
`ifdef RESULT_FIFO_PARITY_EN
    chk("parity_07", out_parity, 1);
`endif
    step(1, 8'h03, 4'h0, 0, 0);
`ifdef RESULT_FIFO_PARITY_EN
    step(0, 8'h00, 4'h0, 1, 0);
    chk("parity_03", out_parity, 0);
`endif
    step(0, 8'h00, 4'h0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
